matmul_apb_slave: RTL and testbench

APB slave front-end of the matrix-multiply accelerator: the block the APB master stimulus drives. It decodes APB transfers into the CONTROL, OPERAND_A, OPERAND_B, FLAGS and SP address windows and holds the control register and the operand A/B line buffers. It issues a start pulse to the calculation engine and returns result (SP) and flag data on reads. It inserts one wait state for SP reads and flags illegal accesses with pslverr_o.

---
 rtl/matmul_apb_if.sv | 28 ++
 rtl/matmul_apb_slave.sv | 246 ++++++++++++++++++++++++
 tb/tb_matmul_apb_slave.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_apb_if.sv
// APB bus bundle between the stimulus master and the matrix-multiply
// accelerator front-end. Signal names keep the slave-side _i/_o view so that
// the slave module reads exactly like a flat-port APB slave.
interface matmul_apb_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_DIM    = 4
);
  logic                  psel_i;
  logic                  penable_i;
  logic                  pwrite_i;
  logic [MAX_DIM-1:0]    pstrb_i;
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic [BUS_WIDTH-1:0]  pwdata_i;
  logic [BUS_WIDTH-1:0]  prdata_o;
  logic                  pready_o;
  logic                  pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/matmul_apb_slave.sv
// APB slave front-end of the matrix-multiply accelerator.
// Holds the CONTROL register, the operand A/B line buffers and the FLAGS
// register, launches the engine with a one-cycle start pulse and returns
// scratch-pad (SP) lines with one wait state.
//
// The APB setup phase (psel high, penable low) is recognised directly from
// the bus; on the edge that ends it the response (pready/pslverr/read data)
// for the following access cycle is captured, so non-SP transfers complete
// with zero wait states and the response comes straight from registers.
//
// Optional build macro: MATMUL_APB_STRB_EN -- when defined, pstrb_i gates
// each DATA_WIDTH lane on CONTROL and OPERAND writes; when undefined every
// write updates all lanes.
module matmul_apb_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  matmul_apb_if.slave                  apb,
  input  logic                         busy_i,
  input  logic                         flags_we_i,
  input  logic [BUS_WIDTH-1:0]         flags_i,
  output logic [$clog2(MAX_DIM)-1:0]   sp_raddr_o,
  input  logic [BUS_WIDTH-1:0]         sp_rdata_i,
  output logic                         start_o,
  output logic [BUS_WIDTH-1:0]         ctrl_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0] op_a_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0] op_b_o,
  output logic                         busy_o
);

  localparam int LW = $clog2(MAX_DIM);

  localparam logic [4:0] WIN_CTRL  = 5'h00;
  localparam logic [4:0] WIN_OPA   = 5'h04;
  localparam logic [4:0] WIN_OPB   = 5'h08;
  localparam logic [4:0] WIN_FLAGS = 5'h0C;
  localparam logic [4:0] WIN_SP    = 5'h10;

  // Stored CONTROL bits: mode, write/read target, N-1, K-1, M-1.
  // Bit 0 (start) is never stored, so it always reads back as 0.
  localparam logic [BUS_WIDTH-1:0] CTRL_MASK = BUS_WIDTH'(32'h0000_3F3E);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // Replace the lanes enabled in en_v with new_v, keep the others from old_v.
  function automatic logic [BUS_WIDTH-1:0] lane_merge(
    input logic [BUS_WIDTH-1:0] old_v,
    input logic [BUS_WIDTH-1:0] new_v,
    input logic [MAX_DIM-1:0]   en_v
  );
    logic [BUS_WIDTH-1:0] res_v;
    res_v = old_v;
    for (int i = 0; i < MAX_DIM; i++) begin
      if (en_v[i]) begin
        res_v[i*DATA_WIDTH +: DATA_WIDTH] = new_v[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return res_v;
  endfunction

  // Transfer FSM and captured response
  state_t                         state_q;
  logic [4:0]                     win_q;
  logic [LW-1:0]                  line_q;
  logic                           wr_q;
  logic                           err_q;
  logic                           sp_rd_q;
  logic [BUS_WIDTH-1:0]           rdata_q;
  logic [LW-1:0]                  sp_raddr_q;

  // Architectural state
  logic [BUS_WIDTH-1:0]               ctrl_q;
  logic [MAX_DIM-1:0][BUS_WIDTH-1:0]  op_a_q;
  logic [MAX_DIM-1:0][BUS_WIDTH-1:0]  op_b_q;
  logic [BUS_WIDTH-1:0]               flags_q;
  logic                               start_q;
  logic                               pend_q;

  // Decode
  logic [4:0]           win_s;
  logic [LW-1:0]        line_s;
  logic                 legal_s;
  logic                 err_s;
  logic [BUS_WIDTH-1:0] rd_raw_s;
  logic [BUS_WIDTH-1:0] rdata_s;
  logic                 setup_s;
  logic                 access_s;
  logic                 commit_s;
  logic [MAX_DIM-1:0]   lane_en_s;
  logic [BUS_WIDTH-1:0] ctrl_new_s;
  logic                 ctrl_start_s;
  logic [BUS_WIDTH-1:0] flags_clr_s;
  logic [BUS_WIDTH-1:0] flags_set_s;
  logic                 unused_s;

  assign win_s    = apb.paddr_i[4:0];
  assign line_s   = apb.paddr_i[5 +: LW];
  assign setup_s  = apb.psel_i && !apb.penable_i;
  assign access_s = (state_q == ST_ACCESS) && apb.psel_i && apb.penable_i;
  assign commit_s = access_s && wr_q && apb.pwrite_i && !err_q && !sp_rd_q;
  assign unused_s = ^{apb.paddr_i[ADDR_WIDTH-1:5+LW], apb.pstrb_i};

`ifdef MATMUL_APB_STRB_EN
  assign lane_en_s = apb.pstrb_i;
`else
  assign lane_en_s = {MAX_DIM{1'b1}};
`endif

  assign ctrl_new_s   = lane_merge(ctrl_q, apb.pwdata_i, lane_en_s) & CTRL_MASK;
  assign ctrl_start_s = lane_en_s[0] && apb.pwdata_i[0];
  assign flags_clr_s  = (commit_s && (win_q == WIN_FLAGS)) ? apb.pwdata_i : {BUS_WIDTH{1'b0}};
  assign flags_set_s  = flags_we_i ? flags_i : {BUS_WIDTH{1'b0}};

  assign busy_o     = busy_i || pend_q;
  assign start_o    = start_q;
  assign ctrl_o     = ctrl_q;
  assign op_a_o     = op_a_q;
  assign op_b_o     = op_b_q;
  assign sp_raddr_o = sp_raddr_q;

  // Window decode, error classification and read data for the upcoming access.
  always_comb begin
    legal_s  = 1'b1;
    rd_raw_s = {BUS_WIDTH{1'b0}};
    case (win_s)
      WIN_CTRL:  rd_raw_s = ctrl_q;
      WIN_OPA:   rd_raw_s = op_a_q[line_s];
      WIN_OPB:   rd_raw_s = op_b_q[line_s];
      WIN_FLAGS: rd_raw_s = flags_q;
      WIN_SP:    rd_raw_s = {BUS_WIDTH{1'b0}};
      default:   legal_s  = 1'b0;
    endcase
    err_s = !legal_s
         || ((win_s == WIN_SP) && apb.pwrite_i)
         || (apb.pwrite_i && busy_o &&
             ((win_s == WIN_CTRL) || (win_s == WIN_OPA) || (win_s == WIN_OPB)));
    if (err_s || apb.pwrite_i) begin
      rdata_s = {BUS_WIDTH{1'b0}};
    end else begin
      rdata_s = rd_raw_s;
    end
  end

  // APB response decoded from the FSM state; SP data is passed through in WAIT.
  always_comb begin
    apb.pready_o  = 1'b0;
    apb.pslverr_o = 1'b0;
    apb.prdata_o  = {BUS_WIDTH{1'b0}};
    case (state_q)
      ST_ACCESS: begin
        apb.pready_o  = !sp_rd_q;
        apb.pslverr_o = !sp_rd_q && err_q;
        apb.prdata_o  = rdata_q;
      end
      ST_WAIT: begin
        apb.pready_o  = 1'b1;
        apb.pslverr_o = 1'b0;
        apb.prdata_o  = sp_rdata_i;
      end
      default: begin
        apb.pready_o  = 1'b0;
        apb.pslverr_o = 1'b0;
        apb.prdata_o  = {BUS_WIDTH{1'b0}};
      end
    endcase
  end

  // Transfer FSM: capture the response at the end of each setup phase, go to
  // WAIT for SP reads, abort to IDLE whenever the access phase is not held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      win_q      <= 5'h00;
      line_q     <= {LW{1'b0}};
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      sp_rd_q    <= 1'b0;
      rdata_q    <= {BUS_WIDTH{1'b0}};
      sp_raddr_q <= {LW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE:   state_q <= setup_s ? ST_ACCESS : ST_IDLE;
        ST_ACCESS: begin
          if (setup_s) begin
            state_q <= ST_ACCESS;
          end else if (access_s && sp_rd_q) begin
            state_q <= ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT:   state_q <= setup_s ? ST_ACCESS : ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
      if (setup_s) begin
        win_q   <= win_s;
        line_q  <= line_s;
        wr_q    <= apb.pwrite_i;
        err_q   <= err_s;
        sp_rd_q <= (win_s == WIN_SP) && !apb.pwrite_i;
        rdata_q <= rdata_s;
        if (win_s == WIN_SP) begin
          sp_raddr_q <= line_s;
        end
      end
    end
  end

  // Register file updates, start pulse / pending-start tracking and flag OR/W1C.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q  <= {BUS_WIDTH{1'b0}};
      op_a_q  <= {(MAX_DIM*BUS_WIDTH){1'b0}};
      op_b_q  <= {(MAX_DIM*BUS_WIDTH){1'b0}};
      flags_q <= {BUS_WIDTH{1'b0}};
      start_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      start_q <= commit_s && (win_q == WIN_CTRL) && ctrl_start_s;
      if (commit_s && (win_q == WIN_CTRL) && ctrl_start_s) begin
        pend_q <= 1'b1;
      end else if (busy_i) begin
        pend_q <= 1'b0;
      end
      if (commit_s) begin
        case (win_q)
          WIN_CTRL: ctrl_q <= ctrl_new_s;
          WIN_OPA:  op_a_q[line_q] <= lane_merge(op_a_q[line_q], apb.pwdata_i, lane_en_s);
          WIN_OPB:  op_b_q[line_q] <= lane_merge(op_b_q[line_q], apb.pwdata_i, lane_en_s);
          default:  ;
        endcase
      end
      // Engine set is ORed after the clear, so it wins on a per-bit collision.
      flags_q <= (flags_q & ~flags_clr_s) | flags_set_s;
    end
  end

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Self-checking bench for matmul_apb_slave: a table of APB transfers with
// expected responses fed through a scoreboard queue, plus hand-written
// sequences for start pulse, flags, abort and reset-in-access.
module tb_matmul_apb_slave;

`ifdef MATMUL_APB_STRB_EN
  localparam bit STRB_ON = 1'b1;
`else
  localparam bit STRB_ON = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         busy_i, flags_we_i;
  logic [31:0]  flags_i, sp_rdata_i;
  logic [1:0]   sp_raddr_o;
  logic         start_o, busy_o;
  logic [31:0]  ctrl_o;
  logic [127:0] op_a_o, op_b_o;
  logic [31:0]  sp_mem [4];

  always #5 clk_i = ~clk_i;

  matmul_apb_if #(.BUS_WIDTH(32), .ADDR_WIDTH(16), .MAX_DIM(4)) bus ();

  matmul_apb_slave #(.DATA_WIDTH(8), .BUS_WIDTH(32), .ADDR_WIDTH(16), .MAX_DIM(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .apb(bus.slave),
    .busy_i(busy_i), .flags_we_i(flags_we_i), .flags_i(flags_i),
    .sp_raddr_o(sp_raddr_o), .sp_rdata_i(sp_rdata_i),
    .start_o(start_o), .ctrl_o(ctrl_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .busy_o(busy_o)
  );

  // Engine scratch-pad model: data valid one cycle after the address.
  always @(posedge clk_i) sp_rdata_i <= sp_mem[sp_raddr_o];

  int start_cnt = 0;
  always @(posedge clk_i) if (start_o) start_cnt++;

  typedef struct {
    string       name;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        busy;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int waits, output logic ok);
    @(negedge clk_i);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = wr;
    bus.paddr_i = addr; bus.pwdata_i = wdata; bus.pstrb_i = strb;
    @(negedge clk_i);
    bus.penable_i = 1'b1;
    waits = 0; ok = 1'b0; rdata = 32'h0; err = 1'b0;
    #1;
    if (!wr && (addr[4:0] == 5'h10)) check("sp_raddr", sp_raddr_o, addr[6:5]);
    for (int c = 0; c < 8; c++) begin
      if (bus.pready_o) begin
        rdata = bus.prdata_o; err = bus.pslverr_o; ok = 1'b1;
        break;
      end
      waits++;
      @(negedge clk_i);
      #1;
    end
    if (ok) begin
      @(posedge clk_i);
      #1;
    end
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
  endtask

  task automatic run_xfer(input string name, input logic wr, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_waits);
    exp_t        e;
    logic [31:0] rdata;
    logic        err, ok;
    int          waits;
    sb.push_back('{exp_rdata, exp_err, exp_waits});
    apb_xfer(wr, addr, wdata, strb, rdata, err, waits, ok);
    e = sb.pop_front();
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no pready_o within 8 cycles, expected %0d wait states", name, e.waits);
    end else begin
      check({name, "/rdata"}, rdata, e.rdata);
      check({name, "/pslverr"}, err, e.err);
      check({name, "/waits"}, waits, e.waits);
    end
  endtask

  initial begin
    sp_mem[0] = 32'hA0A0_0000; sp_mem[1] = 32'h0000_1234;
    sp_mem[2] = 32'h5555_AAAA; sp_mem[3] = 32'hDEAD_BEEF;
    rst_i = 1'b1; busy_i = 1'b0; flags_we_i = 1'b0; flags_i = 32'h0;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    bus.paddr_i = 16'h0; bus.pwdata_i = 32'h0; bus.pstrb_i = 4'h0;

    tbl.push_back('{"opa_wr_l2",   1'b1, 16'h0044, 32'h0403_0201, 4'hF, 1'b0, 32'h0, 1'b0, 0});
    tbl.push_back('{"opa_rd_l2",   1'b0, 16'h0044, 32'h0,         4'hF, 1'b0, 32'h0403_0201, 1'b0, 0});
    tbl.push_back('{"opa_wr_strb", 1'b1, 16'h0044, 32'hFFFF_FFFF, 4'h5, 1'b0, 32'h0, 1'b0, 0});
    tbl.push_back('{"opa_rd_strb", 1'b0, 16'h0044, 32'h0,         4'hF, 1'b0,
                    STRB_ON ? 32'h04FF_02FF : 32'hFFFF_FFFF, 1'b0, 0});
    tbl.push_back('{"opa_wr_s0",   1'b1, 16'h0024, 32'h5A5A_5A5A, 4'h0, 1'b0, 32'h0, 1'b0, 0});
    tbl.push_back('{"opa_rd_l1",   1'b0, 16'h0024, 32'h0,         4'hF, 1'b0,
                    STRB_ON ? 32'h0 : 32'h5A5A_5A5A, 1'b0, 0});
    tbl.push_back('{"opb_wr_l2",   1'b1, 16'h0048, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 1'b0, 0});
    tbl.push_back('{"opb_rd_l0",   1'b0, 16'h0008, 32'h0,         4'hF, 1'b0, 32'h0, 1'b0, 0});
    tbl.push_back('{"opb_rd_l2",   1'b0, 16'h0048, 32'h0,         4'hF, 1'b0, 32'h1122_3344, 1'b0, 0});
    tbl.push_back('{"ctrl_wr",     1'b1, 16'h0000, 32'h0000_FFFE, 4'hF, 1'b0, 32'h0, 1'b0, 0});
    tbl.push_back('{"ctrl_rd",     1'b0, 16'h0000, 32'h0,         4'hF, 1'b0, 32'h0000_3F3E, 1'b0, 0});
    tbl.push_back('{"sp_rd_l1",    1'b0, 16'h0030, 32'h0,         4'hF, 1'b0, 32'h0000_1234, 1'b0, 1});
    tbl.push_back('{"sp_rd_l3",    1'b0, 16'h0070, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1});
    tbl.push_back('{"sp_wr",       1'b1, 16'h0010, 32'h0000_0001, 4'hF, 1'b0, 32'h0, 1'b1, 0});
    tbl.push_back('{"ill_rd",      1'b0, 16'h0014, 32'h0,         4'hF, 1'b0, 32'h0, 1'b1, 0});
    tbl.push_back('{"ill_wr",      1'b1, 16'h001C, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b1, 0});
    tbl.push_back('{"opb_wr_busy", 1'b1, 16'h0048, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0, 1'b1, 0});
    tbl.push_back('{"opb_rd_busy", 1'b0, 16'h0048, 32'h0,         4'hF, 1'b1, 32'h1122_3344, 1'b0, 0});
    tbl.push_back('{"flags_rd0",   1'b0, 16'h000C, 32'h0,         4'hF, 1'b0, 32'h0, 1'b0, 0});

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst/prdata", bus.prdata_o, 32'h0);
    check("rst/pready", bus.pready_o, 1'b0);
    check("rst/pslverr", bus.pslverr_o, 1'b0);
    check("rst/start", start_o, 1'b0);
    check("rst/ctrl", ctrl_o, 32'h0);
    check("rst/op_a", op_a_o, 128'h0);
    check("rst/op_b", op_b_o, 128'h0);
    check("rst/sp_raddr", sp_raddr_o, 2'd0);
    check("rst/busy", busy_o, 1'b0);
    rst_i = 1'b0;

    // Table-driven transfers
    for (int i = 0; i < tbl.size(); i++) begin
      busy_i = tbl[i].busy;
      run_xfer(tbl[i].name, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb,
               tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_waits);
      busy_i = 1'b0;
    end
    check("op_a_line2", op_a_o[95:64], STRB_ON ? 32'h04FF_02FF : 32'hFFFF_FFFF);
    check("op_b_line2", op_b_o[95:64], 32'h1122_3344);
    check("ctrl_o_mask", ctrl_o, 32'h0000_3F3E);
    check("no_start_yet", start_cnt, 0);

    // Start pulse: one cycle, the cycle after commit; busy held until busy_i
    run_xfer("ctrl_start", 1'b1, 16'h0000, 32'h0000_2A01, 4'hF, 32'h0, 1'b0, 0);
    check("start/high", start_o, 1'b1);
    check("start/ctrl_o", ctrl_o, 32'h0000_2A00);
    check("start/busy_o", busy_o, 1'b1);
    @(posedge clk_i); #1;
    check("start/low", start_o, 1'b0);
    check("start/busy_pend", busy_o, 1'b1);
    run_xfer("ctrl_rd_start", 1'b0, 16'h0000, 32'h0, 4'hF, 32'h0000_2A00, 1'b0, 0);
    run_xfer("opa_wr_pend", 1'b1, 16'h0004, 32'h0BAD_0BAD, 4'hF, 32'h0, 1'b1, 0);
    busy_i = 1'b1;
    @(posedge clk_i); #1;
    busy_i = 1'b0;
    #1;
    check("busy_cleared", busy_o, 1'b0);
    check("start_count", start_cnt, 1);
    check("op_a_line0", op_a_o[31:0], 32'h0);

    // Flags: engine OR-set, W1C clear, engine wins on collision
    @(negedge clk_i); flags_we_i = 1'b1; flags_i = 32'h3;
    @(negedge clk_i); flags_we_i = 1'b0; flags_i = 32'h0;
    run_xfer("flags_rd3", 1'b0, 16'h000C, 32'h0, 4'hF, 32'h3, 1'b0, 0);
    run_xfer("flags_w1c", 1'b1, 16'h000C, 32'h1, 4'hF, 32'h0, 1'b0, 0);
    run_xfer("flags_rd2", 1'b0, 16'h000C, 32'h0, 4'hF, 32'h2, 1'b0, 0);
    flags_we_i = 1'b1; flags_i = 32'h2;
    run_xfer("flags_clash", 1'b1, 16'h000C, 32'h2, 4'hF, 32'h0, 1'b0, 0);
    flags_we_i = 1'b0; flags_i = 32'h0;
    run_xfer("flags_rd_win", 1'b0, 16'h000C, 32'h0, 4'hF, 32'h2, 1'b0, 0);
    run_xfer("flags_w1c2", 1'b1, 16'h000C, 32'h2, 4'hF, 32'h0, 1'b0, 0);
    run_xfer("flags_rd_clr", 1'b0, 16'h000C, 32'h0, 4'hF, 32'h0, 1'b0, 0);

    // Setup phase not followed by an access: no commit
    @(negedge clk_i);
    bus.psel_i = 1'b1; bus.pwrite_i = 1'b1; bus.paddr_i = 16'h0028;
    bus.pwdata_i = 32'h0000_0077; bus.pstrb_i = 4'hF;
    @(negedge clk_i);
    bus.psel_i = 1'b0; bus.pwrite_i = 1'b0;
    @(negedge clk_i);
    run_xfer("abort_rd", 1'b0, 16'h0028, 32'h0, 4'hF, 32'h0, 1'b0, 0);

    // Reset asserted in the access phase of an OPERAND_A write
    @(negedge clk_i);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b1;
    bus.paddr_i = 16'h0064; bus.pwdata_i = 32'h0000_0099; bus.pstrb_i = 4'hF;
    @(negedge clk_i);
    bus.penable_i = 1'b1;
    #1;
    check("rstacc/pready_before", bus.pready_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("rstacc/pready_in_rst", bus.pready_o, 1'b0);
    @(negedge clk_i);
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rstacc/op_a", op_a_o, 128'h0);
    check("rstacc/ctrl", ctrl_o, 32'h0);
    check("rstacc/pready", bus.pready_o, 1'b0);
    run_xfer("rstacc_rd", 1'b0, 16'h0064, 32'h0, 4'hF, 32'h0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
